// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter with hold-time limit, driving a shared serial mux.
// One grant at a time; each release is followed by one idle cycle and advances the pointer past the last owner.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic [7:0] d,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       y,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt, sel_nxt, pick;
    logic [7:0] gnt_nxt, hold, hold_nxt;
    logic       timeout_nxt, found, at_limit, release_now;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && req[ptr + 3'(i)]) begin
                pick  = ptr + 3'(i);
                found = 1'b1;
            end
        end
    end

    assign at_limit    = (hold == HOLD_LAST);
    assign release_now = done | ~req[sel] | at_limit;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        hold_nxt    = hold;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    gnt_nxt   = 8'd1 << pick;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    ptr_nxt     = sel + 3'd1;
                    hold_nxt    = '0;
                    // Only a release forced purely by the hold limit counts as a timeout.
                    timeout_nxt = at_limit & ~done & req[sel];
                end else begin
                    hold_nxt = hold + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            gnt     <= '0;
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            gnt     <= gnt_nxt;
            hold    <= hold_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign busy = (state == GRANT);
    assign y    = busy & d[sel];

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum cycles one grant may last; the legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8 bits: request from each of 8 requesters, bit i for requester i.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the channel.
REQ-006 The block SHALL have port d, input, 8 bits: the serial data bit from each requester.
REQ-007 The block SHALL have port sel, output, 3 bits: registered index of the current or last owner, used as the mux select.
REQ-008 The block SHALL have port gnt, output, 8 bits: registered one-hot grant, or all zero.
REQ-009 The block SHALL have port y, output, 1 bit: the shared channel output.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a grant is active.
REQ-011 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT; busy SHALL equal (state==GRANT).
REQ-013 The block SHALL hold a 3-bit round-robin pointer ptr, which gives the highest-priority requester.
REQ-014 In IDLE with req != 0, the block SHALL select the first set req bit found searching ptr, ptr+1, ... modulo 8.
- On the next edge it SHALL enter GRANT with sel = that index, gnt = 1<<index, and hold counter = 0.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE, with gnt = 0 and sel unchanged.
REQ-016 Grant latency SHALL be 1 cycle: req sampled in IDLE at edge N gives gnt valid after edge N.
REQ-017 y SHALL be combinational: y = d[sel] when busy=1, and y = 0 otherwise.
REQ-018 In GRANT, the hold counter (8 bits) SHALL increment each cycle the grant is not released.
REQ-019 In GRANT, the grant SHALL be released at the next edge when any of these holds:
- done=1;
- req[sel]=0;
- hold counter == MAX_HOLD-1.
REQ-020 On release the block SHALL:
- go to IDLE;
- clear gnt to 0;
- set ptr = (sel+1) mod 8;
- keep sel at its last value.
REQ-021 timeout SHALL pulse high for exactly one cycle after a release edge caused only by the hold limit (done=0 and req[sel]=1 in that cycle).
REQ-022 When done or req[sel] deassertion coincides with the hold limit, the release SHALL NOT be flagged as a timeout.
REQ-023 After every release there SHALL be exactly one IDLE cycle (gnt=0) before the next grant, even if requests are pending.
REQ-024 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-025 done SHALL be ignored in IDLE.
REQ-026 Pointer wrap: after a grant to index 7 is released, ptr SHALL become 0.
REQ-027 With MAX_HOLD=1, every grant SHALL last exactly one cycle.

Reset
REQ-028 While rst=1, the block SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- ptr = 0, sel = 0, gnt = 0;
- busy = 0, timeout = 0, y = 0;
- hold counter = 0.
REQ-029 If rst asserts mid-GRANT, the grant SHALL be dropped at once; after rst deasserts, arbitration SHALL restart with ptr = 0.

Verification
REQ-030 Reset: assert rst mid-clock while GRANT with sel=5 -> gnt=0, sel=0, busy=0 before the next edge; first grant after release goes to the lowest set req starting from 0.
REQ-031 Round-robin: req=8'hFF held, done pulsed 1 cycle after each grant -> grant order 0,1,2,...,7,0, with one gnt=0 cycle between grants.
REQ-032 Skip and wrap: ptr=6 with req=8'b0000_0101 -> grant index 0, then ptr=1, next grant index 2.
REQ-033 Timeout: MAX_HOLD=4, req[3] held high, done=0 -> gnt=8'h08 for exactly 4 cycles, then a timeout pulse of 1 cycle, ptr=4.
REQ-034 Data path: grant index 6, d toggles 1,0,1 on d[6] while other d bits are 1 -> y follows 1,0,1; y=0 in the IDLE cycle.
REQ-035 Coincident release: done=1 on the same cycle the hold counter reaches MAX_HOLD-1 -> release, timeout stays 0.
